// File: rtl/fma_unpack.sv
// fma_unpack: operand unpacker at the front of the FMAC.
//
// Accepts a packed IEEE-754 double triple (x, y, z) on a valid/ready handshake and splits
// each operand into sign, 13-bit two's-complement biased exponent and 53-bit mantissa with
// an explicit leading bit. It also produces per-operand class flags (zero/inf/nan/snan/denorm).
//
// Optional feature macro: FMA_DENORM_EN
//   defined   : denormals are normalized iteratively (at most SHIFT_STEP bits per cycle) in
//               the NORM state; the exponent may go negative.
//   undefined : denormals are flushed to signed zero (denorm flag kept); latency is 1 cycle.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid / in_ready     operand triple handshake (in_ready high only in IDLE)
//   x, y, z                 packed double operands
//   out_valid / out_ready   result handshake (out_valid high only in DONE)
//   xs/ys/zs                signs
//   xe/ye/ze                13-bit biased exponents
//   xm/ym/zm                53-bit mantissas, bit 52 is the leading bit
//   x/y/z{zero,inf,nan,snan,denorm}  class flags, fixed at acceptance
module fma_unpack #(
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x,
    input  logic [63:0] y,
    input  logic [63:0] z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        xs,
    output logic        ys,
    output logic        zs,
    output logic [12:0] xe,
    output logic [12:0] ye,
    output logic [12:0] ze,
    output logic [52:0] xm,
    output logic [52:0] ym,
    output logic [52:0] zm,
    output logic        xzero,
    output logic        yzero,
    output logic        zzero,
    output logic        xinf,
    output logic        yinf,
    output logic        zinf,
    output logic        xnan,
    output logic        ynan,
    output logic        znan,
    output logic        xsnan,
    output logic        ysnan,
    output logic        zsnan,
    output logic        xdenorm,
    output logic        ydenorm,
    output logic        zdenorm
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StNorm = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Index 0 = x, 1 = y, 2 = z throughout.
    logic [2:0]        s_q, s_d;
    logic [2:0][12:0]  e_q, e_d;
    logic [2:0][52:0]  m_q, m_d;
    logic [2:0]        zero_q, zero_d;
    logic [2:0]        inf_q, inf_d;
    logic [2:0]        nan_q, nan_d;
    logic [2:0]        snan_q, snan_d;
    logic [2:0]        den_q, den_d;

    logic [2:0][63:0]  op;
    logic [2:0]        dec_s, dec_zero, dec_inf, dec_nan, dec_snan, dec_den;
    logic [2:0][12:0]  dec_e;
    logic [2:0][52:0]  dec_m;

    assign op = {z, y, x};

    // Field decode of the incoming operands.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dec_s[i]    = op[i][63];
            dec_zero[i] = 1'b0;
            dec_inf[i]  = 1'b0;
            dec_nan[i]  = 1'b0;
            dec_snan[i] = 1'b0;
            dec_den[i]  = 1'b0;
            dec_e[i]    = 13'd0;
            dec_m[i]    = 53'd0;
            if (op[i][62:52] == 11'd0) begin
                if (op[i][51:0] == 52'd0) begin
                    dec_zero[i] = 1'b1;
                end else begin
                    dec_den[i] = 1'b1;
`ifdef FMA_DENORM_EN
                    dec_e[i] = 13'd1;
                    dec_m[i] = {1'b0, op[i][51:0]};
`else
                    // Flush to signed zero; the sign is kept in dec_s.
                    dec_zero[i] = 1'b1;
`endif
                end
            end else if (op[i][62:52] == 11'h7FF) begin
                dec_inf[i]  = (op[i][51:0] == 52'd0);
                dec_nan[i]  = (op[i][51:0] != 52'd0);
                dec_snan[i] = (op[i][51:0] != 52'd0) && !op[i][51];
                dec_e[i]    = 13'd2047;
                dec_m[i]    = {1'b1, op[i][51:0]};
            end else begin
                dec_e[i] = {2'b00, op[i][62:52]};
                dec_m[i] = {1'b1, op[i][51:0]};
            end
        end
    end

`ifdef FMA_DENORM_EN
    logic [2:0][52:0] nrm_m;
    logic [2:0][12:0] nrm_e;
    logic [2:0][5:0]  nrm_lz;
    logic [2:0][5:0]  nrm_sh;
    logic [2:0]       nrm_fin;

    function automatic logic [5:0] clz53(input logic [52:0] v);
        logic [5:0] n;
        n = 6'd53;
        // Ascending scan: the highest set bit is the last one to write n.
        for (int b = 0; b < 53; b++) begin
            if (v[b]) n = 6'(52 - b);
        end
        return n;
    endfunction

    // One normalization step per unfinished denormal operand.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nrm_lz[i] = clz53(m_q[i]);
            nrm_sh[i] = (nrm_lz[i] < 6'(SHIFT_STEP)) ? nrm_lz[i] : 6'(SHIFT_STEP);
            nrm_m[i]  = m_q[i];
            nrm_e[i]  = e_q[i];
            if (den_q[i] && !m_q[i][52]) begin
                nrm_m[i] = m_q[i] << nrm_sh[i];
                nrm_e[i] = e_q[i] - {7'd0, nrm_sh[i]};
            end
            // Non-denormal operands (including zeros) never need shifting.
            nrm_fin[i] = !den_q[i] || nrm_m[i][52];
        end
    end
`else
    logic unused_shift_step;
    assign unused_shift_step = (SHIFT_STEP != 0);
`endif

    // Next-state and datapath load.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        e_d     = e_q;
        m_d     = m_q;
        zero_d  = zero_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        snan_d  = snan_q;
        den_d   = den_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d    = dec_s;
                    e_d    = dec_e;
                    m_d    = dec_m;
                    zero_d = dec_zero;
                    inf_d  = dec_inf;
                    nan_d  = dec_nan;
                    snan_d = dec_snan;
                    den_d  = dec_den;
`ifdef FMA_DENORM_EN
                    state_d = (|dec_den) ? StNorm : StDone;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef FMA_DENORM_EN
            StNorm: begin
                e_d = nrm_e;
                m_d = nrm_m;
                if (&nrm_fin) state_d = StDone;
            end
`endif
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            zero_q  <= '0;
            inf_q   <= '0;
            nan_q   <= '0;
            snan_q  <= '0;
            den_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            m_q     <= m_d;
            zero_q  <= zero_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
            snan_q  <= snan_d;
            den_q   <= den_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

    assign xs = s_q[0];
    assign ys = s_q[1];
    assign zs = s_q[2];
    assign xe = e_q[0];
    assign ye = e_q[1];
    assign ze = e_q[2];
    assign xm = m_q[0];
    assign ym = m_q[1];
    assign zm = m_q[2];

    assign xzero   = zero_q[0];
    assign yzero   = zero_q[1];
    assign zzero   = zero_q[2];
    assign xinf    = inf_q[0];
    assign yinf    = inf_q[1];
    assign zinf    = inf_q[2];
    assign xnan    = nan_q[0];
    assign ynan    = nan_q[1];
    assign znan    = nan_q[2];
    assign xsnan   = snan_q[0];
    assign ysnan   = snan_q[1];
    assign zsnan   = snan_q[2];
    assign xdenorm = den_q[0];
    assign ydenorm = den_q[1];
    assign zdenorm = den_q[2];

endmodule

// File: tb/tb_fma_unpack.sv
// Directed self-checking bench for fma_unpack (SHIFT_STEP = 8).
module tb_fma_unpack;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] x = '0, y = '0, z = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        xs, ys, zs;
    logic [12:0] xe, ye, ze;
    logic [52:0] xm, ym, zm;
    logic        xzero, yzero, zzero, xinf, yinf, zinf, xnan, ynan, znan;
    logic        xsnan, ysnan, zsnan, xdenorm, ydenorm, zdenorm;

    int total = 0;
    int bad = 0;

    // Order: zero[x,y,z], inf[x,y,z], nan[x,y,z], snan[x,y,z], denorm[x,y,z]
    logic [14:0] flags;
    assign flags = {xzero, yzero, zzero, xinf, yinf, zinf, xnan, ynan, znan,
                    xsnan, ysnan, zsnan, xdenorm, ydenorm, zdenorm};

    fma_unpack #(.SHIFT_STEP(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z),
        .out_valid(out_valid), .out_ready(out_ready),
        .xs(xs), .ys(ys), .zs(zs),
        .xe(xe), .ye(ye), .ze(ze),
        .xm(xm), .ym(ym), .zm(zm),
        .xzero(xzero), .yzero(yzero), .zzero(zzero),
        .xinf(xinf), .yinf(yinf), .zinf(zinf),
        .xnan(xnan), .ynan(ynan), .znan(znan),
        .xsnan(xsnan), .ysnan(ysnan), .zsnan(zsnan),
        .xdenorm(xdenorm), .ydenorm(ydenorm), .zdenorm(zdenorm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a triple for exactly one edge; caller has checked in_ready.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        x = a; y = b; z = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Latency counted with the accepting edge as cycle 1; bounded.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        total++;
        if ({xs, ys, zs, xe, ye, ze, xm, ym, zm, flags} !== '0) begin
            bad++;
            $display("FAIL reset_data: xe=%h xm=%h flags=%b want all 0", xe, xm, flags);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        int lat;
        send(64'h3FF0000000000000, 64'h4000000000000000, 64'hBFF8000000000000);
        wait_out(lat);
        total++;
        if (!out_valid || lat != 1) begin
            bad++;
            $display("FAIL normal_lat: got %0d (valid=%b) want 1", lat, out_valid);
        end
        total++;
        if ({xs, ys, zs} !== 3'b001 || xe !== 13'h3FF || ye !== 13'h400 || ze !== 13'h3FF) begin
            bad++;
            $display("FAIL normal_se: s=%b%b%b xe=%h ye=%h ze=%h want 001 3ff 400 3ff",
                     xs, ys, zs, xe, ye, ze);
        end
        total++;
        if (xm !== 53'h10000000000000 || ym !== 53'h10000000000000
            || zm !== 53'h18000000000000 || flags !== '0) begin
            bad++;
            $display("FAIL normal_mf: xm=%h ym=%h zm=%h flags=%b want 10..,10..,18.., 0",
                     xm, ym, zm, flags);
        end
        drain();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL normal_ret: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_specials();
        int lat;
        send(64'h7FF0000000000000, 64'h7FF4000000000000, 64'h8000000000000000);
        wait_out(lat);
        total++;
        if (!out_valid || lat != 1) begin
            bad++;
            $display("FAIL spec_lat: got %0d want 1", lat);
        end
        total++;
        if (flags !== 15'b001_100_010_010_000) begin
            bad++;
            $display("FAIL spec_flags: got %b want 001100010010000", flags);
        end
        total++;
        if (xe !== 13'h7FF || xm !== 53'h10000000000000 || ye !== 13'h7FF
            || ym !== 53'h14000000000000 || zs !== 1'b1 || ze !== 13'h0 || zm !== 53'h0) begin
            bad++;
            $display("FAIL spec_fields: xe=%h xm=%h ye=%h ym=%h zs=%b ze=%h zm=%h",
                     xe, xm, ye, ym, zs, ze, zm);
        end
        drain();
        // Quiet NaN, negative infinity, positive zero.
        send(64'h7FF8000000000000, 64'hFFF0000000000000, 64'h0000000000000000);
        wait_out(lat);
        total++;
        if (flags !== 15'b001_010_100_000_000 || ys !== 1'b1 || xm !== 53'h18000000000000) begin
            bad++;
            $display("FAIL spec_qnan: flags=%b ys=%b xm=%h want 001010100000000 1 18..",
                     flags, ys, xm);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [12:0] exe;
        exe = 13'h400;
        send(64'h4000000000000000, 64'h3FF0000000000000, 64'hBFF8000000000000);
        wait_out(lat);
        // Offer a different triple during the hold; it must not be taken.
        x = 64'h7FF0000000000000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || xe !== exe
                || xm !== 53'h10000000000000 || xinf !== 1'b0 || zm !== 53'h18000000000000) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b xe=%h xinf=%b zm=%h", i,
                         out_valid, in_ready, xe, xinf, zm);
            end
        end
        in_valid = 1'b0;
        drain();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

`ifdef FMA_DENORM_EN
    task automatic test_denorm();
        int lat;
        send(64'h0000000000000001, 64'h3FF0000000000000, 64'h0008000000000000);
        wait_out(lat);
        total++;
        if (!out_valid || lat != 8) begin
            bad++;
            $display("FAIL denorm_lat: got %0d want 8", lat);
        end
        total++;
        if (xe !== 13'h1FCD || xm !== 53'h10000000000000 || xdenorm !== 1'b1 || xzero !== 1'b0) begin
            bad++;
            $display("FAIL denorm_x: xe=%h xm=%h xden=%b want 1fcd 10.. 1", xe, xm, xdenorm);
        end
        // z has lz=1: exponent 1-1=0.
        total++;
        if (ze !== 13'h0 || zm !== 53'h10000000000000 || zdenorm !== 1'b1 || ydenorm !== 1'b0
            || ye !== 13'h3FF) begin
            bad++;
            $display("FAIL denorm_z: ze=%h zm=%h zden=%b yden=%b ye=%h", ze, zm, zdenorm,
                     ydenorm, ye);
        end
        drain();
        send(64'h3FF0000000000000, 64'h0008000000000000, 64'h3FF0000000000000);
        wait_out(lat);
        total++;
        if (lat != 2 || ye !== 13'h0 || ym !== 53'h10000000000000) begin
            bad++;
            $display("FAIL denorm_lz1: lat=%0d ye=%h ym=%h want 2 0 10..", lat, ye, ym);
        end
        drain();
    endtask

    task automatic test_abort();
        int lat;
        send(64'h0000000000000001, 64'h3FF0000000000000, 64'h3FF0000000000000);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {xe, xm, flags} !== '0) begin
            bad++;
            $display("FAIL abort: valid=%b ready=%b xe=%h xm=%h flags=%b", out_valid,
                     in_ready, xe, xm, flags);
        end
        @(negedge clk);
        reset_n = 1'b1;
        send(64'h3FF0000000000000, 64'h4000000000000000, 64'hBFF8000000000000);
        wait_out(lat);
        total++;
        if (lat != 1 || xe !== 13'h3FF || xdenorm !== 1'b0) begin
            bad++;
            $display("FAIL abort_next: lat=%0d xe=%h xden=%b want 1 3ff 0", lat, xe, xdenorm);
        end
        drain();
    endtask
`else
    task automatic test_flush();
        int lat;
        send(64'h000FFFFFFFFFFFFF, 64'h8000000000000001, 64'h3FF0000000000000);
        wait_out(lat);
        total++;
        if (!out_valid || lat != 1) begin
            bad++;
            $display("FAIL flush_lat: got %0d want 1", lat);
        end
        total++;
        if (xzero !== 1'b1 || xdenorm !== 1'b1 || xe !== 13'h0 || xm !== 53'h0 || xs !== 1'b0) begin
            bad++;
            $display("FAIL flush_x: zero=%b den=%b xe=%h xm=%h xs=%b", xzero, xdenorm, xe, xm, xs);
        end
        total++;
        if (yzero !== 1'b1 || ydenorm !== 1'b1 || ys !== 1'b1 || ym !== 53'h0 || zdenorm !== 1'b0) begin
            bad++;
            $display("FAIL flush_y: zero=%b den=%b ys=%b ym=%h zden=%b", yzero, ydenorm, ys,
                     ym, zdenorm);
        end
        drain();
    endtask

    task automatic test_abort();
        int lat;
        send(64'hBFF8000000000000, 64'h4000000000000000, 64'h7FF0000000000000);
        tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {xs, xe, xm, flags} !== '0) begin
            bad++;
            $display("FAIL abort: valid=%b ready=%b xe=%h xm=%h flags=%b", out_valid,
                     in_ready, xe, xm, flags);
        end
        @(negedge clk);
        reset_n = 1'b1;
        send(64'h3FF0000000000000, 64'h4000000000000000, 64'hBFF8000000000000);
        wait_out(lat);
        total++;
        if (lat != 1 || xe !== 13'h3FF || zinf !== 1'b0) begin
            bad++;
            $display("FAIL abort_next: lat=%0d xe=%h zinf=%b want 1 3ff 0", lat, xe, zinf);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_backpressure();
`ifdef FMA_DENORM_EN
        test_denorm();
`else
        test_flush();
`endif
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fma_unpack.md
# fma_unpack

Sequential operand unpacker at the front of the FMAC. It accepts three packed IEEE-754 double operands (X, Y, Z) over a valid/ready handshake and splits each into sign, extended 13-bit biased exponent and 53-bit mantissa with an explicit leading bit. It also produces the per-operand class flags used by the exponent and special-case paths. Denormal operands are normalized iteratively, so the downstream exponent path always sees normalized mantissas. This block decodes the fields that the result-exponent path later re-encodes.

## Interface
Parameters:
- SHIFT_STEP, 8: maximum left-shift per cycle during denormal normalization; legal range 1..53.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  block can accept a triple.
- x, y, z  in  64 each  packed double operands.
- out_valid  out  1  unpacked result valid.
- out_ready  in  1  consumer accepts the result.
- xs, ys, zs  out  1 each  signs.
- xe, ye, ze  out  13 each  biased exponent, two's complement; may be negative for denormals.
- xm, ym, zm  out  53 each  mantissa; bit 52 is the explicit leading bit.
- xzero, yzero, zzero  out  1 each  operand is ±0.
- xinf, yinf, zinf  out  1 each  operand is ±∞.
- xnan, ynan, znan  out  1 each  operand is NaN.
- xsnan, ysnan, zsnan  out  1 each  operand is a signalling NaN.
- xdenorm, ydenorm, zdenorm  out  1 each  operand was denormal.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - NORM: shifting.
  - DONE: out_valid=1.
- IDLE → register all three operands when in_valid && in_ready. Go to NORM if any operand is denormal (and FMA_DENORM_EN is defined); otherwise go to DONE.
- Decode per operand, with E = bits 62:52 and F = bits 51:0:
  - E=0, F=0: zero flag set; exponent 0; mantissa 0.
  - E=0, F≠0: denorm flag set; exponent initialized to 1; mantissa {0,F}.
  - E=2047: inf flag if F=0, otherwise nan flag; snan = nan && ~F[51]; exponent 2047; mantissa {1,F}.
  - Otherwise: exponent {2'b0,E}; mantissa {1,F}.
- NORM, each cycle, per unfinished denormal operand:
  - lz = leading zeros of the 53-bit mantissa.
  - Shift left by min(SHIFT_STEP, lz) and subtract the same amount from the exponent (13-bit wraparound arithmetic).
  - The operand is finished when mantissa bit 52 = 1.
  - Go to DONE on the edge where all operands are finished.
- Final denormal exponent is 1 − lz_initial. Example: 0x...0001 gives −51 = 13'h1FCD.
- DONE: hold all outputs stable while out_ready=0. When out_ready=1, go to IDLE.
- No input is accepted in NORM or DONE; in_ready=0 in those states.
- Class flags are computed at acceptance and do not change during NORM.

## Timing
- Reset (asynchronous, on the reset_n falling edge):
  - state=IDLE, so in_ready=1 and out_valid=0.
  - All data and flag outputs are 0.
- Reset asserted mid-NORM or mid-DONE aborts immediately; the in-flight triple is discarded.
- Latency, from the accepting edge to out_valid=1:
  - 1 cycle if no operand is denormal.
  - Otherwise 1 + ceil(max_lz / SHIFT_STEP) cycles.
  - Worst case with SHIFT_STEP=8: 1 + 7 = 8 cycles.
- Throughput: one triple every latency + 1 cycles at best, because the handshake returns to IDLE before the next accept.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.

## Configuration
- FMA_DENORM_EN defined: denormals are normalized as described above and the denorm flags are reported.
- FMA_DENORM_EN undefined: denormal inputs are flushed to zero.
  - Mantissa 0, exponent 0, zero flag set, denorm flag still set, sign preserved.
  - The NORM state and the shifter are not built; latency is always 1 cycle.

## Test plan
- Normal operands: x=0x3FF0000000000000, y=0x4000000000000000, z=0xBFF8000000000000.
  - One cycle later: xe=0x3FF, ye=0x400, ze=0x3FF, zs=1.
  - xm=0x10000000000000, zm=0x18000000000000; all flags 0.
- Smallest denormal x=0x0000000000000001, with SHIFT_STEP=8 and FMA_DENORM_EN defined:
  - out_valid 8 cycles after accept.
  - xe=0x1FCD, xm=0x10000000000000, xdenorm=1.
- Specials: x=0x7FF0000000000000, y=0x7FF4000000000000, z=0x8000000000000000.
  - xinf=1; ynan=1, ysnan=1; zzero=1, zs=1.
  - out_valid after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Outputs stay constant and in_ready stays 0.
  - out_ready=1 for one cycle → IDLE, in_ready=1 next cycle.
- Reset mid-operation: assert reset_n=0 during NORM of the smallest-denormal case.
  - out_valid=0, in_ready=1 and all outputs 0 immediately.
  - The next accepted normal triple completes in 1 cycle.
- Without FMA_DENORM_EN, x=0x000FFFFFFFFFFFFF:
  - xzero=1, xdenorm=1, xe=0, xm=0.
  - Latency 1 cycle.
